// File: rtl/pool_window_sequencer_if.sv
// Bundle of layer-control, source-read, window, and destination-write signals
// shared between the 2x2 pooling window sequencer and its environment.
interface pool_window_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic                start;
  logic [ADDR_W-1:0]   cfg_width;
  logic [ADDR_W-1:0]   cfg_height;
  logic [ADDR_W-1:0]   cfg_src_base;
  logic [ADDR_W-1:0]   cfg_dst_base;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic [4*DATA_W-1:0] win_data;
  logic                win_valid;
  logic [DATA_W-1:0]   pool_result;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  modport master (
    input  start, cfg_width, cfg_height, cfg_src_base, cfg_dst_base,
    input  rd_data, pool_result,
    output busy, done, rd_en, rd_addr, win_data, win_valid,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, cfg_width, cfg_height, cfg_src_base, cfg_dst_base,
    output rd_data, pool_result,
    input  busy, done, rd_en, rd_addr, win_data, win_valid,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_window_sequencer.sv
// Walks a feature map in non-overlapping 2x2 windows, feeds each window to the
// pooling unit, and writes the delayed pooled result to the destination buffer.
module pool_window_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 12,
  parameter int POOL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pool_window_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   w_q, w_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [ADDR_W-1:0]   hp_q, hp_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   row_base1_q, row_base1_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   col_pair_q, col_pair_d;
  logic [ADDR_W-1:0]   row_pair_q, row_pair_d;
  logic [1:0]          rd_phase_q, rd_phase_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_vld_q, rd_vld_d;
  logic [1:0]          cap_phase_q, cap_phase_d;
  logic [4*DATA_W-1:0] win_q, win_d;
  logic                win_valid_q, win_valid_d;
  logic [POOL_LAT-1:0] pipe_q, pipe_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic dims_ok;
  logic last_col;
  logic last_row;

  assign dims_ok  = (bus.cfg_width >= TWO) && (bus.cfg_height >= TWO);
  assign last_col = (col_pair_q == wp_q - ONE);
  assign last_row = (row_pair_q == hp_q - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      wp_q        <= '0;
      hp_q        <= '0;
      row_base_q  <= '0;
      row_base1_q <= '0;
      col_q       <= '0;
      col_pair_q  <= '0;
      row_pair_q  <= '0;
      rd_phase_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      cap_phase_q <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      pipe_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      wp_q        <= wp_d;
      hp_q        <= hp_d;
      row_base_q  <= row_base_d;
      row_base1_q <= row_base1_d;
      col_q       <= col_d;
      col_pair_q  <= col_pair_d;
      row_pair_q  <= row_pair_d;
      rd_phase_q  <= rd_phase_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      cap_phase_q <= cap_phase_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      pipe_q      <= pipe_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    wp_d        = wp_q;
    hp_d        = hp_q;
    row_base_d  = row_base_q;
    row_base1_d = row_base1_q;
    col_d       = col_q;
    col_pair_d  = col_pair_q;
    row_pair_d  = row_pair_q;
    rd_phase_d  = rd_phase_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    rd_vld_d    = rd_en_q;
    cap_phase_d = cap_phase_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    pipe_d      = (pipe_q << 1) | POOL_LAT'(win_valid_q);
    wr_en_d     = pipe_q[POOL_LAT-1];
    wr_addr_d   = wr_en_q ? (wr_addr_q + ONE) : wr_addr_q;
    wr_data_d   = pipe_q[POOL_LAT-1] ? bus.pool_result : wr_data_q;

    // Pixel k of a window lands in element k after four right shifts.
    if (rd_vld_q) begin
      win_d       = {bus.rd_data, win_q[4*DATA_W-1:DATA_W]};
      cap_phase_d = cap_phase_q + 2'd1;
      win_valid_d = (cap_phase_q == 2'd3);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (dims_ok) begin
            state_d     = FETCH;
            w_d         = bus.cfg_width;
            wp_d        = bus.cfg_width >> 1;
            hp_d        = bus.cfg_height >> 1;
            row_base_d  = bus.cfg_src_base;
            row_base1_d = bus.cfg_src_base + bus.cfg_width;
            col_d       = '0;
            col_pair_d  = '0;
            row_pair_d  = '0;
            rd_phase_d  = '0;
            rd_en_d     = 1'b1;
            rd_addr_d   = bus.cfg_src_base;
            cap_phase_d = '0;
            wr_addr_d   = bus.cfg_dst_base;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        rd_phase_d = rd_phase_q + 2'd1;
        case (rd_phase_q)
          2'd0: rd_addr_d = row_base_q + col_q + ONE;
          2'd1: rd_addr_d = row_base1_q + col_q;
          2'd2: rd_addr_d = row_base1_q + col_q + ONE;
          default: begin
            // Row bases advance by whole row pairs, so no r*W product is needed.
            if (last_col && last_row) begin
              rd_en_d = 1'b0;
              state_d = DRAIN;
            end else if (last_col) begin
              row_base_d  = row_base1_q + w_q;
              row_base1_d = row_base1_q + (w_q << 1);
              col_d       = '0;
              col_pair_d  = '0;
              row_pair_d  = row_pair_q + ONE;
              rd_addr_d   = row_base1_q + w_q;
            end else begin
              col_d      = col_q + TWO;
              col_pair_d = col_pair_q + ONE;
              rd_addr_d  = row_base_q + col_q + TWO;
            end
          end
        endcase
      end
      DRAIN: begin
        if (wr_en_q && !rd_vld_q && !win_valid_q && (pipe_q == '0)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.win_data  = win_q;
  assign bus.win_valid = win_valid_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule
